// File: rtl/quat_tdm_scheduler_if.sv
// Quaternion TDM scheduler bus bundle.
// Sensor inputs, converter handshake and per-channel results.
interface quat_tdm_scheduler_if #(
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 16,
  parameter int RES_W        = 32,
  parameter int MAX_INFLIGHT = 4
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [NUM_CH-1:0]          in_valid;
  logic [NUM_CH*4*DATA_W-1:0] in_quat;
  logic                       eng_valid;
  logic                       eng_ready;
  logic [4*DATA_W-1:0]        eng_quat;
  logic                       res_valid;
  logic [3*RES_W-1:0]         res_euler;
  logic [NUM_CH-1:0]          out_valid;
  logic [NUM_CH*3*RES_W-1:0]  out_euler;
  logic [NUM_CH-1:0]          overrun;
  logic                       spurious;
  logic [CNT_W-1:0]           inflight;

  modport master (
    input  in_valid, in_quat, eng_ready, res_valid, res_euler,
    output eng_valid, eng_quat, out_valid, out_euler,
    output overrun, spurious, inflight
  );

  modport slave (
    output in_valid, in_quat, eng_ready, res_valid, res_euler,
    input  eng_valid, eng_quat, out_valid, out_euler,
    input  overrun, spurious, inflight
  );
endinterface

// File: rtl/quat_tdm_scheduler.sv
// Time-shares one quaternion-to-Euler converter across sensor channels.
// Round-robin grant, one pending slot per channel, in-order tag FIFO.
module quat_tdm_scheduler #(
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 16,
  parameter int RES_W        = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input logic clk,
  input logic rst_n,
  quat_tdm_scheduler_if.master io
);
  localparam int QW    = 4 * DATA_W;
  localparam int EW    = 3 * RES_W;
  localparam int TAG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [NUM_CH-1:0]                  pend_q, pend_d;
  logic [NUM_CH-1:0][QW-1:0]          slot_q;
  logic [NUM_CH-1:0]                  ovr_q, ovr_d;
  logic [TAG_W-1:0]                   rr_q;
  logic                               eng_valid_q;
  logic [QW-1:0]                      eng_quat_q;
  logic [MAX_INFLIGHT-1:0][TAG_W-1:0] tag_q;
  logic [PTR_W-1:0]                   wr_q, rd_q;
  logic [CNT_W-1:0]                   cnt_q;
  logic [NUM_CH-1:0]                  outv_q;
  logic [NUM_CH-1:0][EW-1:0]          eul_q;
  logic                               spur_q;

  logic              found, grant, full, pop;
  logic [TAG_W-1:0]  gnt, ci;
  logic [NUM_CH-1:0] gnt_oh;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (int'(p) == MAX_INFLIGHT - 1) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CNT_W'(MAX_INFLIGHT));
  assign grant = found && !full && (!eng_valid_q || io.eng_ready);
  assign pop   = io.res_valid && (cnt_q != '0);

  // Round-robin search for the first pending channel from rr_q upward.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    ci    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ci = TAG_W'((int'(rr_q) + k) % NUM_CH);
      if (!found && pend_q[ci]) begin
        found = 1'b1;
        gnt   = ci;
      end
    end
  end

  // Pending and overrun next state; a granted slot may refill same cycle.
  always_comb begin
    gnt_oh = '0;
    if (grant) gnt_oh[gnt] = 1'b1;
    pend_d = io.in_valid | (pend_q & ~gnt_oh);
    ovr_d  = io.in_valid & pend_q & ~gnt_oh;
  end

  // Per-channel sample slots, pending flags and overrun pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovr_q  <= '0;
      slot_q <= '0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      for (int i = 0; i < NUM_CH; i++)
        if (io.in_valid[i]) slot_q[i] <= io.in_quat[i*QW +: QW];
    end
  end

  // Staging register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_valid_q <= 1'b0;
      eng_quat_q  <= '0;
      rr_q        <= '0;
    end else if (grant) begin
      eng_valid_q <= 1'b1;
      eng_quat_q  <= slot_q[gnt];
      rr_q <= (int'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;
    end else if (io.eng_ready) begin
      eng_valid_q <= 1'b0;
    end
  end

  // Tag FIFO: grants push their channel, results pop in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (grant) begin
        tag_q[wr_q] <= gnt;
        wr_q        <= nxt(wr_q);
      end
      if (pop) rd_q <= nxt(rd_q);
      if (grant && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !grant) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Result routing to the tagged channel, spurious result detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outv_q <= '0;
      eul_q  <= '0;
      spur_q <= 1'b0;
    end else begin
      outv_q <= '0;
      spur_q <= io.res_valid && (cnt_q == '0);
      if (pop) begin
        outv_q[tag_q[rd_q]] <= 1'b1;
        eul_q[tag_q[rd_q]]  <= io.res_euler;
      end
    end
  end

  assign io.eng_valid = eng_valid_q;
  assign io.eng_quat  = eng_quat_q;
  assign io.out_valid = outv_q;
  assign io.out_euler = eul_q;
  assign io.overrun   = ovr_q;
  assign io.spurious  = spur_q;
  assign io.inflight  = cnt_q;
endmodule

// File: tb/tb_quat_tdm_scheduler.sv
// Scoreboard bench for quat_tdm_scheduler (4 channels, 4 tags).
// Directed stimulus pushes expectations; a negedge monitor checks them.
module tb_quat_tdm_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int RW  = 32;
  localparam int MI  = 4;
  localparam int QW  = 4 * DW;
  localparam int EW  = 3 * RW;

  typedef logic [NCH*EW-1:0] w_t;
  typedef struct {
    logic [NCH-1:0] oh;
    logic [EW-1:0]  eul;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  quat_tdm_scheduler_if #(
    .NUM_CH(NCH), .DATA_W(DW), .RES_W(RW), .MAX_INFLIGHT(MI)
  ) io ();

  quat_tdm_scheduler #(
    .NUM_CH(NCH), .DATA_W(DW), .RES_W(RW), .MAX_INFLIGHT(MI)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(io)
  );

  logic [QW-1:0]             exp_eng[$];
  out_t                      exp_out[$];
  logic [NCH-1:0]            exp_ovr[$];
  logic                      exp_spur[$];
  logic [NCH-1:0][EW-1:0]    mdl_eul;
  out_t                      mon_e;
  int checks = 0;
  int failures = 0;

  task automatic cmp(input string n, input w_t act, input w_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic unexp(input string n, input w_t act);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected output %0h, expected none", n, act);
  endtask

  function automatic logic [QW-1:0] q(input int ch, input int n);
    logic [DW-1:0] c;
    c = DW'(32'h1000 * (ch + 1) + n);
    return {c, c ^ 16'h00FF, c ^ 16'hFF00, ~c};
  endfunction

  function automatic logic [EW-1:0] r(input int n);
    return {RW'(n * 32'h0101_0101), RW'(-n), RW'(n << 20)};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [NCH-1:0] v, input int n);
    io.in_valid = v;
    for (int i = 0; i < NCH; i++)
      if (v[i]) io.in_quat[i*QW +: QW] = q(i, n);
  endtask

  task automatic res(input int n, input logic [NCH-1:0] oh);
    out_t t;
    t.oh  = oh;
    t.eul = r(n);
    exp_out.push_back(t);
    io.res_valid = 1'b1;
    io.res_euler = r(n);
    tick();
    io.res_valid = 1'b0;
  endtask

  task automatic spur(input int n);
    exp_spur.push_back(1'b1);
    io.res_valid = 1'b1;
    io.res_euler = r(n);
    tick();
    io.res_valid = 1'b0;
  endtask

  // Monitor: every DUT presentation pops and checks one expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (io.eng_valid && io.eng_ready) begin
        if (exp_eng.size() == 0) unexp("eng_req", w_t'(io.eng_quat));
        else cmp("eng_quat", w_t'(io.eng_quat), w_t'(exp_eng.pop_front()));
      end
      if (|io.out_valid) begin
        if (exp_out.size() == 0) unexp("out_valid", w_t'(io.out_valid));
        else begin
          mon_e = exp_out.pop_front();
          cmp("out_valid", w_t'(io.out_valid), w_t'(mon_e.oh));
          for (int i = 0; i < NCH; i++)
            if (mon_e.oh[i]) mdl_eul[i] = mon_e.eul;
          cmp("out_euler", w_t'(io.out_euler), w_t'(mdl_eul));
        end
      end
      if (|io.overrun) begin
        if (exp_ovr.size() == 0) unexp("overrun", w_t'(io.overrun));
        else cmp("overrun", w_t'(io.overrun), w_t'(exp_ovr.pop_front()));
      end
      if (io.spurious) begin
        if (exp_spur.size() == 0) unexp("spurious", w_t'(io.spurious));
        else begin
          void'(exp_spur.pop_front());
          cmp("spur_out_valid", w_t'(io.out_valid), w_t'(0));
          cmp("spur_out_euler", w_t'(io.out_euler), w_t'(mdl_eul));
        end
      end
    end
  end

  initial begin
    io.in_valid  = '0;
    io.in_quat   = '0;
    io.eng_ready = 1'b0;
    io.res_valid = 1'b0;
    io.res_euler = '0;
    mdl_eul      = '0;
    tick(3);
    rst_n = 1'b1;
    tick();
    cmp("rst_eng_valid", w_t'(io.eng_valid), w_t'(0));
    cmp("rst_inflight", w_t'(io.inflight), w_t'(0));
    cmp("rst_pulses", w_t'({io.out_valid, io.overrun, io.spurious}), w_t'(0));
    cmp("rst_euler", w_t'(io.out_euler), w_t'(0));

    // Two channels at once: ch0 issued in cycle 2, ch1 in cycle 3.
    io.eng_ready = 1'b1;
    send(4'b0011, 1);
    exp_eng.push_back(q(0, 1));
    exp_eng.push_back(q(1, 1));
    tick();
    io.in_valid = '0;
    cmp("a_c1_idle", w_t'(io.eng_valid), w_t'(0));
    tick();
    cmp("a_c2_valid", w_t'(io.eng_valid), w_t'(1));
    cmp("a_c2_quat", w_t'(io.eng_quat), w_t'(q(0, 1)));
    tick();
    cmp("a_c3_quat", w_t'(io.eng_quat), w_t'(q(1, 1)));
    cmp("a_c3_inflight", w_t'(io.inflight), w_t'(2));
    tick();
    cmp("a_c4_idle", w_t'(io.eng_valid), w_t'(0));
    res(1, 4'b0001);
    cmp("a_inflight_1", w_t'(io.inflight), w_t'(1));
    res(2, 4'b0010);
    cmp("a_inflight_0", w_t'(io.inflight), w_t'(0));
    tick(2);

    // Converter stalled: hold staged sample, third sample overruns.
    io.eng_ready = 1'b0;
    send(4'b0001, 2);
    tick();
    io.in_valid = '0;
    tick();
    send(4'b0001, 3);
    tick();
    io.in_valid = '0;
    tick();
    send(4'b0001, 4);
    exp_ovr.push_back(4'b0001);
    tick();
    io.in_valid = '0;
    cmp("b_hold_quat", w_t'(io.eng_quat), w_t'(q(0, 2)));
    cmp("b_inflight", w_t'(io.inflight), w_t'(1));
    tick();
    cmp("b_hold_valid", w_t'(io.eng_valid), w_t'(1));
    cmp("b_hold_quat2", w_t'(io.eng_quat), w_t'(q(0, 2)));
    exp_eng.push_back(q(0, 2));
    exp_eng.push_back(q(0, 4));
    io.eng_ready = 1'b1;
    tick(3);
    cmp("b_inflight_2", w_t'(io.inflight), w_t'(2));
    res(3, 4'b0001);
    res(4, 4'b0001);
    tick();
    cmp("b_inflight_0", w_t'(io.inflight), w_t'(0));

    // Move rr_ptr to 2 with a single ch1 request.
    send(4'b0010, 5);
    exp_eng.push_back(q(1, 5));
    tick();
    io.in_valid = '0;
    tick(3);
    res(5, 4'b0010);
    tick();

    // All pending from rr_ptr=2: order 2,3,0,1, then FIFO full.
    send(4'b1111, 6);
    exp_eng.push_back(q(2, 6));
    exp_eng.push_back(q(3, 6));
    exp_eng.push_back(q(0, 6));
    exp_eng.push_back(q(1, 6));
    tick();
    io.in_valid = '0;
    tick(5);
    cmp("c_full_inflight", w_t'(io.inflight), w_t'(4));
    cmp("c_full_idle", w_t'(io.eng_valid), w_t'(0));
    send(4'b0101, 7);
    tick();
    io.in_valid = '0;
    tick(2);
    cmp("c_stall_valid", w_t'(io.eng_valid), w_t'(0));
    cmp("c_stall_inflight", w_t'(io.inflight), w_t'(4));
    exp_eng.push_back(q(2, 7));
    exp_eng.push_back(q(0, 7));
    res(6, 4'b0100);
    cmp("c_pop_inflight", w_t'(io.inflight), w_t'(3));
    tick();
    cmp("c_regrant_quat", w_t'(io.eng_quat), w_t'(q(2, 7)));
    cmp("c_regrant_inflight", w_t'(io.inflight), w_t'(4));
    res(7, 4'b1000);
    res(8, 4'b0001);
    cmp("c_pushpop_inflight", w_t'(io.inflight), w_t'(3));
    res(9, 4'b0010);
    res(10, 4'b0100);
    res(11, 4'b0001);
    tick();
    cmp("c_drain_inflight", w_t'(io.inflight), w_t'(0));

    // Result with nothing outstanding.
    spur(12);
    tick();
    cmp("d_euler_hold", w_t'(io.out_euler), w_t'(mdl_eul));

    // Reset with two tags outstanding and both slots pending.
    io.eng_ready = 1'b0;
    send(4'b0011, 8);
    exp_eng.push_back(q(1, 8));
    tick();
    io.in_valid = '0;
    tick();
    io.eng_ready = 1'b1;
    tick();
    io.eng_ready = 1'b0;
    send(4'b0011, 9);
    tick();
    io.in_valid = '0;
    cmp("e_pre_inflight", w_t'(io.inflight), w_t'(2));
    cmp("e_pre_quat", w_t'(io.eng_quat), w_t'(q(0, 8)));
    rst_n = 1'b0;
    mdl_eul = '0;
    tick();
    cmp("e_rst_outs", w_t'({io.eng_valid, io.eng_quat, io.out_valid,
        io.overrun, io.spurious, io.inflight}), w_t'(0));
    cmp("e_rst_euler", w_t'(io.out_euler), w_t'(0));
    rst_n = 1'b1;
    tick(3);
    cmp("e_no_grant", w_t'(io.eng_valid), w_t'(0));
    spur(13);
    tick(2);
    cmp("e_inflight", w_t'(io.inflight), w_t'(0));

    cmp("q_eng_left", w_t'(exp_eng.size()), w_t'(0));
    cmp("q_out_left", w_t'(exp_out.size()), w_t'(0));
    cmp("q_ovr_left", w_t'(exp_ovr.size()), w_t'(0));
    cmp("q_spur_left", w_t'(exp_spur.size()), w_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/quat_tdm_scheduler.md
QUAT_TDM_SCHEDULER -- requirements
Module: quat_tdm_scheduler

Interface
REQ-001 Parameter NUM_CH, default 2: number of sensor channels; legal range 2..8.
REQ-002 Parameter DATA_W, default 16: width of one signed quaternion component.
REQ-003 Parameter RES_W, default 32: width of one signed Euler angle (roll, pitch, yaw).
REQ-004 Parameter MAX_INFLIGHT, default 4: tag FIFO depth; power of two, 1..16.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  in  NUM_CH  per-channel one-cycle quaternion sample strobe.
REQ-008 in_quat  in  NUM_CH*4*DATA_W  per channel {w,x,y,z}; channel i at slice i.
REQ-009 eng_valid  out  1  request to the shared converter.
REQ-010 eng_ready  in  1  converter accepts the request.
REQ-011 eng_quat  out  4*DATA_W  {w,x,y,z} of the staged request.
REQ-012 res_valid  in  1  one-cycle converter result strobe; results return in request order.
REQ-013 res_euler  in  3*RES_W  {roll,pitch,yaw} result.
REQ-014 out_valid  out  NUM_CH  per-channel one-cycle result strobe.
REQ-015 out_euler  out  NUM_CH*3*RES_W  per-channel held result registers.
REQ-016 overrun  out  NUM_CH  one-cycle pulse when a pending sample is overwritten.
REQ-017 spurious  out  1  one-cycle pulse when res_valid arrives with no outstanding tag.
REQ-018 inflight  out  $clog2(MAX_INFLIGHT+1)  tag FIFO occupancy.

Function
REQ-019 Each channel has a one-entry pending slot; in_valid[i] loads in_quat slice i into the slot and sets pending[i].
REQ-020 If in_valid[i] arrives while pending[i]=1 and channel i is not granted that cycle, the newer sample overwrites the slot and overrun[i] pulses the next cycle.
REQ-021 If in_valid[i] coincides with a grant of channel i, the granted (old) sample is issued, the new sample is stored, pending[i] stays 1, and no overrun occurs.
REQ-022 Staging register = eng_valid/eng_quat; once eng_valid=1, eng_quat is held stable until eng_valid && eng_ready.
REQ-023 A grant occurs when any pending bit is set, the tag FIFO is not full, and the staging register is empty or being accepted that cycle.
REQ-024 Grant is round-robin: search starts at rr_ptr, ascending modulo NUM_CH; after a grant to channel g, rr_ptr becomes (g+1) mod NUM_CH; rr_ptr is unchanged when there is no grant.
REQ-025 On a grant, the slot data loads into the staging register, pending[g] clears (unless REQ-021 applies), and index g is pushed into the tag FIFO.
REQ-026 Timing: with an idle block, in_valid in cycle 0 gives eng_valid=1 in cycle 2.
REQ-027 On res_valid with a non-empty FIFO, pop tag t, load res_euler into out_euler slice t, and assert out_valid[t] for exactly the next cycle.
REQ-028 When a push and a pop occur in the same cycle, both take effect and inflight is unchanged.
REQ-029 On res_valid with an empty FIFO, the result is discarded, no out_valid is asserted, and spurious pulses the next cycle.
REQ-030 The FIFO counts the staged request plus requests in the converter; when full, grants stall, pending slots keep absorbing samples under REQ-020, and no data is lost beyond overwrite.
REQ-031 Slices of out_euler hold their value between updates; only the tagged slice changes.

Reset
REQ-032 While rst_n=0, clear: pending, slots, staging register, eng_valid, tag FIFO, inflight, out_valid, out_euler, overrun, spurious; set rr_ptr=0.
REQ-033 Reset asserted mid-operation discards all outstanding tags; results returning after reset release are treated as spurious (REQ-029).
REQ-034 All outputs are 0 from the first clock after reset release until new stimulus arrives.

Verification
REQ-035 NUM_CH=2, eng_ready=1: in_valid=2'b11 in cycle 0 gives eng_quat=ch0 in cycle 2 and ch1 in cycle 3; the FIFO holds 0,1; results R0,R1 give out_valid=01 then 10 with matching out_euler.
REQ-036 Hold eng_ready=0: in_valid[0] is pulsed 3 times; eng_quat stays at the first sample; overrun[0] pulses once, for the third sample; after ready, the second-issued request carries the third sample.
REQ-037 NUM_CH=4, all channels pending continuously with rr_ptr=2: the grant order is 2,3,0,1,2.
REQ-038 MAX_INFLIGHT=4, results withheld: after 4 grants inflight=4 and eng_valid stays with no new grant; one res_valid makes inflight=3, after which the next grant proceeds.
REQ-039 res_valid with inflight=0 gives spurious=1 for one cycle, with out_valid=0 and out_euler unchanged.
REQ-040 Assert rst_n=0 with inflight=2 and pending=11: all outputs are 0 on the next edge; a later res_valid produces spurious only.
